encoder_motion_sequencer: RTL and testbench
===========================================

# encoder_motion_sequencer

Avalon-MM slave that sequences a single encoder-fed axis: decodes the quadrature A/B/Z inputs into a 16-bit position, runs a homing cycle that seeks the Z index, then drives the axis to a programmed target within a tolerance window. It sits between the Qsys control bus, the encoder pins and the motor driver's enable/direction inputs. It replaces ad-hoc software polling of the encoder count with a hardware state machine.

## Interface
- `ID_VALUE`, default `32'hEA680010`: constant returned at address 0.
- `POS_W`, default `16`: position counter width, two's complement.
- `rsi_MRST_reset`, input, 1: asynchronous, active-high reset.
- `csi_MCLK_clk`, input, 1: clock; all logic is in this single domain.
- `avs_ctrl_address`, input, 3: register select.
- `avs_ctrl_writedata`, input, 32: write data.
- `avs_ctrl_byteenable`, input, 4: ignored; writes are always full-word.
- `avs_ctrl_write`, `avs_ctrl_read`, input, 1 each: bus strobes.
- `avs_ctrl_readdata`, output, 32: registered read data; reset value 0.
- `avs_ctrl_waitrequest`, output, 1: tied to 0.
- `A`, `B`, `Z`, input, 1 each: asynchronous encoder signals.
- `motor_en`, output, 1: drive enable; reset value 0.
- `motor_dir`, output, 1: 1 = positive, 0 = negative; reset value 0.
- `irq`, output, 1: level interrupt, set on DONE or FAULT entry, cleared by a write to STATUS; reset value 0.

## Operation
- Registers:
  - 0 ID (read-only).
  - 1 CTRL (write-only). Bit 0 HOME, bit 1 MOVE, bit 2 ABORT. Bits are single-cycle pulses and are not stored.
  - 2 TARGET[15:0].
  - 3 POSITION. Read returns the live count, sign-extended. A write loads the count and is ignored while busy.
  - 4 STATUS: [2:0] state, bit 4 done, bit 5 fault, bit 6 busy. Any write clears done, fault and irq.
  - 5 TIMEOUT[23:0].
  - 6 TOL[7:0].
  - 7 reads 0.
- All writable registers reset to 0 except TIMEOUT, which resets to 24'hFFFFFF.
- Decoder: A, B and Z each pass through a 2-flop synchronizer followed by an edge register. 4x decoding gives ±1 per valid transition. A Gray-illegal transition (both A and B change) is ignored and sets the sticky STATUS bit 7, which a STATUS write clears. Position wraps modulo 2^16.
- FSM states (encoding): IDLE=0, SEEK=1, MOVE=2, DONE=3, FAULT=4.
  - IDLE → SEEK on HOME. `motor_en` = 1, `motor_dir` = 0.
  - IDLE → MOVE on MOVE.
  - HOME and MOVE written together: HOME wins. On reaching the index the FSM then enters MOVE automatically.
  - SEEK: on a synchronized Z rising edge, position is cleared to 0 in that cycle (the clear overrides any simultaneous step), then → MOVE if a move is pending, otherwise → DONE.
  - MOVE: err = TARGET − position, computed in 17 bits. `motor_dir` = (err > 0). When |err| ≤ TOL → DONE.
  - DONE and FAULT: `motor_en` = 0. Both states accept HOME or MOVE exactly as IDLE does.
  - ABORT in any state → IDLE. `motor_en` = 0 in the next cycle. done and fault are unchanged.
  - HOME or MOVE while in SEEK or MOVE is ignored.
- Reset mid-operation: the FSM goes to IDLE, position goes to 0, and the motor outputs drop asynchronously.

## Timing
- Read latency: 1 cycle, with `avs_ctrl_readdata` registered on the cycle after address and read are presented.
- Encoder edge to POSITION update: 3 clocks.
- CTRL write to FSM state change and `motor_en` change: 1 clock.
- Tolerance met to DONE and `motor_en` = 0: 1 clock.
- `irq` asserts in the same cycle the FSM enters DONE or FAULT.

## Configuration
- `ENCODER_SEQ_TIMEOUT_EN`:
  - Defined: a 24-bit watchdog reloads from TIMEOUT on entry to SEEK or MOVE and decrements every clock in those states. Reaching 0 → FAULT, with fault=1 and `irq`=1. Any position step reloads the watchdog.
  - Undefined: no watchdog, register 5 reads 0, and FAULT is unreachable.

## Structure
- Shared package `encoder_seq_pkg`:
  - FSM state enum.
  - Register address constants.
  - STATUS bit indices.
  - `ID_VALUE`.
- Sub-module `quad_decoder`: synchronizers, edge detection and 4x decoding. Outputs `step`, `step_dir`, `index_rise`, `illegal`.
- Top level: register file, position counter, FSM, watchdog.

## Test plan
- Reset, then read addresses 0/3/4 → 32'hEA680010, 0, 0. `motor_en` = 0.
- 8 full forward quadrature cycles → POSITION = 32. 8 reverse cycles → 0. One more reverse edge → 32'hFFFFFFFF.
- HOME, 5 reverse edges, Z pulse → POSITION = 0, STATUS state = DONE, done = 1, `irq` = 1, `motor_en` = 0. Writing STATUS clears `irq`.
- TARGET = 100, TOL = 2, MOVE, forward edges → `motor_dir` = 1. DONE is entered on the cycle after POSITION reaches 98.
- During MOVE, ABORT → state IDLE and `motor_en` = 0 within 1 clock. An immediately following MOVE is accepted.
- With `ENCODER_SEQ_TIMEOUT_EN` defined: TIMEOUT = 50, HOME with no encoder edges → FAULT after 50 clocks, fault = 1, `irq` = 1.

Source files
------------

// File: rtl/encoder_seq_pkg.sv
// Shared definitions for the encoder motion sequencer: FSM state encoding,
// register map, STATUS bit positions, CTRL bit positions and the ID constant.
package encoder_seq_pkg;

    localparam logic [31:0] ID_VALUE = 32'hEA680010;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSeek  = 3'd1,
        StMove  = 3'd2,
        StDone  = 3'd3,
        StFault = 3'd4
    } seq_state_e;

    localparam logic [2:0] AddrId       = 3'd0;
    localparam logic [2:0] AddrCtrl     = 3'd1;
    localparam logic [2:0] AddrTarget   = 3'd2;
    localparam logic [2:0] AddrPosition = 3'd3;
    localparam logic [2:0] AddrStatus   = 3'd4;
    localparam logic [2:0] AddrTimeout  = 3'd5;
    localparam logic [2:0] AddrTol      = 3'd6;

    localparam int unsigned CtrlHomeBit  = 0;
    localparam int unsigned CtrlMoveBit  = 1;
    localparam int unsigned CtrlAbortBit = 2;

    localparam int unsigned StatusDoneBit    = 4;
    localparam int unsigned StatusFaultBit   = 5;
    localparam int unsigned StatusBusyBit    = 6;
    localparam int unsigned StatusIllegalBit = 7;

endpackage

// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-flop synchronizers and an edge register on A, B and Z,
// then 4x decoding. Positive direction is A leading B ({A,B}: 00,10,11,01).
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   a, b, z          raw asynchronous encoder inputs
//   step             one valid Gray transition this cycle
//   step_dir         1 = +1, 0 = -1 (meaningful only with step)
//   index_rise       synchronized rising edge on Z
//   illegal          A and B changed together (transition ignored)
module quad_decoder (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic z,
    output logic step,
    output logic step_dir,
    output logic index_rise,
    output logic illegal
);
    // [0] first synchronizer flop, [1] second
    logic [1:0] a_sync, b_sync, z_sync;
    logic       a_prev, b_prev, z_prev;
    logic       a_chg, b_chg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sync <= '0;
            b_sync <= '0;
            z_sync <= '0;
            a_prev <= 1'b0;
            b_prev <= 1'b0;
            z_prev <= 1'b0;
        end else begin
            a_sync <= {a_sync[0], a};
            b_sync <= {b_sync[0], b};
            z_sync <= {z_sync[0], z};
            a_prev <= a_sync[1];
            b_prev <= b_sync[1];
            z_prev <= z_sync[1];
        end
    end

    assign a_chg      = a_sync[1] ^ a_prev;
    assign b_chg      = b_sync[1] ^ b_prev;
    assign step       = a_chg ^ b_chg;
    assign illegal    = a_chg & b_chg;
    // Forward transitions all satisfy new_A != old_B
    assign step_dir   = a_sync[1] ^ b_prev;
    assign index_rise = z_sync[1] & ~z_prev;

endmodule

// File: rtl/encoder_motion_sequencer.sv
// Avalon-MM slave sequencing one encoder-fed axis: quadrature position counter,
// Z-index homing, and move-to-target within a tolerance window.
// Optional watchdog: define ENCODER_SEQ_TIMEOUT_EN to enable the TIMEOUT
// register and the FAULT path; otherwise register 5 reads 0.
// Ports:
//   rsi_MRST_reset, csi_MCLK_clk   async active-high reset, clock
//   avs_ctrl_*                     Avalon-MM slave (1-cycle registered reads)
//   A, B, Z                        asynchronous encoder inputs
//   motor_en, motor_dir            driver enable / direction (1 = positive)
//   irq                            level interrupt on DONE/FAULT entry
module encoder_motion_sequencer #(
    parameter logic [31:0] ID_VALUE = encoder_seq_pkg::ID_VALUE,
    parameter int unsigned POS_W    = 16
) (
    input  logic        rsi_MRST_reset,
    input  logic        csi_MCLK_clk,
    input  logic [2:0]  avs_ctrl_address,
    input  logic [31:0] avs_ctrl_writedata,
    input  logic [3:0]  avs_ctrl_byteenable,
    input  logic        avs_ctrl_write,
    input  logic        avs_ctrl_read,
    output logic [31:0] avs_ctrl_readdata,
    output logic        avs_ctrl_waitrequest,
    input  logic        A,
    input  logic        B,
    input  logic        Z,
    output logic        motor_en,
    output logic        motor_dir,
    output logic        irq
);
    import encoder_seq_pkg::*;

    localparam logic [POS_W-1:0] PosOne = POS_W'(1);

    seq_state_e       state_q;
    logic [POS_W-1:0] position_q, target_q;
    logic [7:0]       tol_q;
    logic             motor_en_q, motor_dir_q, irq_q;
    logic             done_q, fault_q, illegal_q, move_pending_q;
    logic [31:0]      readdata_q, rdata;

    logic step, step_dir, index_rise, illegal;
    logic wr_ctrl, wr_status, cmd_home, cmd_move, cmd_abort, busy;
    logic [POS_W:0] err, err_mag, tol_ext;
    logic err_pos, target_pos, in_tol, wd_fire;
    logic unused_bits;

    quad_decoder u_quad_decoder (
        .clk        (csi_MCLK_clk),
        .rst        (rsi_MRST_reset),
        .a          (A),
        .b          (B),
        .z          (Z),
        .step       (step),
        .step_dir   (step_dir),
        .index_rise (index_rise),
        .illegal    (illegal)
    );

    assign wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == AddrCtrl);
    assign wr_status = avs_ctrl_write && (avs_ctrl_address == AddrStatus);
    assign cmd_home  = wr_ctrl & avs_ctrl_writedata[CtrlHomeBit];
    assign cmd_move  = wr_ctrl & avs_ctrl_writedata[CtrlMoveBit];
    assign cmd_abort = wr_ctrl & avs_ctrl_writedata[CtrlAbortBit];
    assign busy      = (state_q == StSeek) || (state_q == StMove);

    // Signed error in POS_W+1 bits cannot overflow
    assign err        = {target_q[POS_W-1], target_q} - {position_q[POS_W-1], position_q};
    assign err_mag    = err[POS_W] ? (~err + 1'b1) : err;
    assign tol_ext    = (POS_W+1)'(tol_q);
    assign in_tol     = err_mag <= tol_ext;
    assign err_pos    = ~err[POS_W] && (err != '0);
    assign target_pos = ~target_q[POS_W-1] && (target_q != '0);

`ifdef ENCODER_SEQ_TIMEOUT_EN
    logic [23:0] timeout_q, wd_q;

    // Idle states keep the counter primed so entry into SEEK/MOVE starts full
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            wd_q <= 24'hFFFFFF;
        end else if (!busy || step || (state_q == StSeek && index_rise)) begin
            wd_q <= timeout_q;
        end else begin
            wd_q <= wd_q - 24'd1;
        end
    end
    assign wd_fire = busy && !step && (wd_q <= 24'd1);
`else
    assign wd_fire = 1'b0;
`endif

    // Position counter: index clear beats bus load beats encoder step
    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            position_q <= '0;
        end else if (state_q == StSeek && index_rise) begin
            position_q <= '0;
        end else if (avs_ctrl_write && avs_ctrl_address == AddrPosition && !busy) begin
            position_q <= avs_ctrl_writedata[POS_W-1:0];
        end else if (step) begin
            position_q <= step_dir ? position_q + PosOne : position_q - PosOne;
        end
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            state_q        <= StIdle;
            motor_en_q     <= 1'b0;
            motor_dir_q    <= 1'b0;
            move_pending_q <= 1'b0;
            done_q         <= 1'b0;
            fault_q        <= 1'b0;
            irq_q          <= 1'b0;
        end else begin
            // Clear first so a same-cycle DONE/FAULT entry still sets
            if (wr_status) begin
                done_q  <= 1'b0;
                fault_q <= 1'b0;
                irq_q   <= 1'b0;
            end
            if (cmd_abort) begin
                state_q        <= StIdle;
                motor_en_q     <= 1'b0;
                move_pending_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StDone, StFault: begin
                        if (cmd_home) begin
                            state_q        <= StSeek;
                            motor_en_q     <= 1'b1;
                            motor_dir_q    <= 1'b0;
                            move_pending_q <= cmd_move;
                        end else if (cmd_move) begin
                            state_q        <= StMove;
                            motor_en_q     <= 1'b1;
                            motor_dir_q    <= err_pos;
                            move_pending_q <= 1'b0;
                        end
                    end
                    StSeek: begin
                        if (index_rise) begin
                            move_pending_q <= 1'b0;
                            if (move_pending_q) begin
                                // Position is zero from the next cycle on
                                state_q     <= StMove;
                                motor_dir_q <= target_pos;
                            end else begin
                                state_q    <= StDone;
                                motor_en_q <= 1'b0;
                                done_q     <= 1'b1;
                                irq_q      <= 1'b1;
                            end
                        end else if (wd_fire) begin
                            state_q    <= StFault;
                            motor_en_q <= 1'b0;
                            fault_q    <= 1'b1;
                            irq_q      <= 1'b1;
                        end
                    end
                    StMove: begin
                        if (in_tol) begin
                            state_q    <= StDone;
                            motor_en_q <= 1'b0;
                            done_q     <= 1'b1;
                            irq_q      <= 1'b1;
                        end else if (wd_fire) begin
                            state_q    <= StFault;
                            motor_en_q <= 1'b0;
                            fault_q    <= 1'b1;
                            irq_q      <= 1'b1;
                        end else begin
                            motor_dir_q <= err_pos;
                        end
                    end
                    default: begin
                        state_q    <= StIdle;
                        motor_en_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (avs_ctrl_address)
            AddrId:       rdata = ID_VALUE;
            AddrTarget:   rdata = 32'(target_q);
            AddrPosition: rdata = {{(32-POS_W){position_q[POS_W-1]}}, position_q};
            AddrStatus: begin
                rdata[2:0]              = state_q;
                rdata[StatusDoneBit]    = done_q;
                rdata[StatusFaultBit]   = fault_q;
                rdata[StatusBusyBit]    = busy;
                rdata[StatusIllegalBit] = illegal_q;
            end
`ifdef ENCODER_SEQ_TIMEOUT_EN
            AddrTimeout:  rdata = 32'(timeout_q);
`endif
            AddrTol:      rdata = 32'(tol_q);
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            target_q   <= '0;
            tol_q      <= '0;
            illegal_q  <= 1'b0;
            readdata_q <= '0;
`ifdef ENCODER_SEQ_TIMEOUT_EN
            timeout_q  <= 24'hFFFFFF;
`endif
        end else begin
            if (avs_ctrl_write && avs_ctrl_address == AddrTarget) begin
                target_q <= avs_ctrl_writedata[POS_W-1:0];
            end
            if (avs_ctrl_write && avs_ctrl_address == AddrTol) begin
                tol_q <= avs_ctrl_writedata[7:0];
            end
`ifdef ENCODER_SEQ_TIMEOUT_EN
            if (avs_ctrl_write && avs_ctrl_address == AddrTimeout) begin
                timeout_q <= avs_ctrl_writedata[23:0];
            end
`endif
            illegal_q <= illegal | (illegal_q & ~wr_status);
            if (avs_ctrl_read) begin
                readdata_q <= rdata;
            end
        end
    end

    assign avs_ctrl_readdata    = readdata_q;
    assign avs_ctrl_waitrequest = 1'b0;
    assign motor_en             = motor_en_q;
    assign motor_dir            = motor_dir_q;
    assign irq                  = irq_q;

    assign unused_bits = ^{avs_ctrl_byteenable, avs_ctrl_writedata};

endmodule

// File: tb/tb_encoder_motion_sequencer.sv
// Self-checking bench: a behavioural model of the register map, position count
// and sequencing rules is checked against the DUT on every clock, plus
// hand-computed expectations from the directed scenarios.
module tb_encoder_motion_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = 4'hF;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        a = 1'b0, b = 1'b0, z = 1'b0;
    logic        motor_en, motor_dir, irq;

    always #5 clk = ~clk;

    encoder_motion_sequencer dut (
        .rsi_MRST_reset       (rst),
        .csi_MCLK_clk         (clk),
        .avs_ctrl_address     (address),
        .avs_ctrl_writedata   (writedata),
        .avs_ctrl_byteenable  (byteenable),
        .avs_ctrl_write       (write),
        .avs_ctrl_read        (read),
        .avs_ctrl_readdata    (readdata),
        .avs_ctrl_waitrequest (waitrequest),
        .A                    (a),
        .B                    (b),
        .Z                    (z),
        .motor_en             (motor_en),
        .motor_dir            (motor_dir),
        .irq                  (irq)
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0]  m_state;
    bit          m_en, m_dir, m_irq, m_done, m_fault, m_ill, m_pend;
    logic [15:0] m_pos, m_target;
    logic [7:0]  m_tol;
    logic [23:0] m_timeout;
    int          m_since, m_limit;
    logic [31:0] m_rd;
    bit   [2:0]  ha, hb, hz;  // input samples, [0] newest

    function automatic int phase(bit av, bit bv);
        case ({av, bv})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 3'd0; m_en = 0; m_dir = 0; m_irq = 0; m_done = 0; m_fault = 0;
        m_ill = 0; m_pend = 0; m_pos = '0; m_target = '0; m_tol = '0;
        m_timeout = 24'hFFFFFF; m_since = 0; m_limit = 0; m_rd = '0;
        ha = '0; hb = '0; hz = '0;
    endtask

    task automatic enter_end(input logic [2:0] st);
        m_state = st; m_en = 0; m_irq = 1;
        if (st == 3'd3) m_done = 1; else m_fault = 1;
    endtask

    task automatic watchdog(input bit stepped);
`ifdef ENCODER_SEQ_TIMEOUT_EN
        if (stepped) begin
            m_since = 0; m_limit = int'(m_timeout);
        end else if (m_since + 1 >= m_limit) begin
            enter_end(3'd4);
        end else begin
            m_since++;
        end
`else
        if (stepped) m_since = 0;
`endif
    endtask

    task automatic arm_watchdog();
        m_since = 0; m_limit = int'(m_timeout);
    endtask

    task automatic model_step();
        int d, err, mag;
        bit idx, busy, home, mv, ab, stepped;
        logic [15:0] npos;
        d = (phase(ha[1], hb[1]) - phase(ha[2], hb[2]) + 4) % 4;
        stepped = (d == 1) || (d == 3);
        idx = hz[1] && !hz[2];
        err = int'($signed(m_target)) - int'($signed(m_pos));
        mag = (err < 0) ? -err : err;
        busy = (m_state == 3'd1) || (m_state == 3'd2);
        if (read) begin
            case (address)
                3'd0: m_rd = 32'hEA680010;
                3'd2: m_rd = {16'h0, m_target};
                3'd3: m_rd = {{16{m_pos[15]}}, m_pos};
                3'd4: m_rd = {24'h0, m_ill, busy, m_fault, m_done, 1'b0, m_state};
`ifdef ENCODER_SEQ_TIMEOUT_EN
                3'd5: m_rd = {8'h0, m_timeout};
`endif
                3'd6: m_rd = {24'h0, m_tol};
                default: m_rd = '0;
            endcase
        end
        if (m_state == 3'd1 && idx) npos = '0;
        else if (write && address == 3'd3 && !busy) npos = writedata[15:0];
        else if (d == 1) npos = m_pos + 16'd1;
        else if (d == 3) npos = m_pos - 16'd1;
        else npos = m_pos;
        if (write && address == 3'd4) begin
            m_done = 0; m_fault = 0; m_irq = 0; m_ill = 0;
        end
        if (d == 2) m_ill = 1;
        home = write && address == 3'd1 && writedata[0];
        mv   = write && address == 3'd1 && writedata[1];
        ab   = write && address == 3'd1 && writedata[2];
        if (ab) begin
            m_state = 3'd0; m_en = 0; m_pend = 0;
        end else if (!busy) begin
            if (home) begin
                m_state = 3'd1; m_en = 1; m_dir = 0; m_pend = mv; arm_watchdog();
            end else if (mv) begin
                m_state = 3'd2; m_en = 1; m_dir = (err > 0); arm_watchdog();
            end
        end else if (m_state == 3'd1) begin
            if (idx) begin
                if (m_pend) begin
                    m_state = 3'd2; m_dir = ($signed(m_target) > 0); m_pend = 0;
                    arm_watchdog();
                end else begin
                    enter_end(3'd3);
                end
            end else begin
                watchdog(stepped);
            end
        end else begin
            if (mag <= int'(m_tol)) enter_end(3'd3);
            else begin
                m_dir = (err > 0);
                watchdog(stepped);
            end
        end
        if (write && address == 3'd2) m_target = writedata[15:0];
        if (write && address == 3'd6) m_tol = writedata[7:0];
`ifdef ENCODER_SEQ_TIMEOUT_EN
        if (write && address == 3'd5) m_timeout = writedata[23:0];
`endif
        m_pos = npos;
        ha = {ha[1:0], a}; hb = {hb[1:0], b}; hz = {hz[1:0], z};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                check("motor_en", {31'b0, motor_en}, {31'b0, m_en});
                check("motor_dir", {31'b0, motor_dir}, {31'b0, m_dir});
                check("irq", {31'b0, irq}, {31'b0, m_irq});
                check("readdata", readdata, m_rd);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [1:0] gray_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int ph = 0;
    logic [31:0] r;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] ad, input logic [31:0] d);
        address = ad; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] ad, output logic [31:0] d);
        address = ad; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    // n = +1 forward, -1 reverse, 2 illegal double change
    task automatic set_phase(input int n);
        ph = (ph + n + 4) % 4;
        {a, b} = gray_tab[ph];
    endtask

    task automatic enc(input int n);
        set_phase(n);
        cyc(2);
    endtask

    initial begin
        cyc(2);
        rst = 1'b0;
        chk_en = 1'b1;

        rd(3'd0, r); check("id", r, 32'hEA680010);
        rd(3'd3, r); check("pos_reset", r, 32'd0);
        rd(3'd4, r); check("status_reset", r, 32'd0);
        check("en_reset", {31'b0, motor_en}, 32'd0);
        check("waitreq", {31'b0, waitrequest}, 32'd0);

        repeat (32) enc(1);
        cyc(4); rd(3'd3, r); check("pos_fwd32", r, 32'd32);
        repeat (32) enc(-1);
        cyc(4); rd(3'd3, r); check("pos_back0", r, 32'd0);
        enc(-1);
        cyc(4); rd(3'd3, r); check("pos_minus1", r, 32'hFFFFFFFF);

        // Homing
        wr(3'd1, 32'h1);
        check("home_en", {31'b0, motor_en}, 32'd1);
        repeat (5) enc(-1);
        z = 1'b1; cyc(3); z = 1'b0; cyc(4);
        rd(3'd3, r); check("home_pos", r, 32'd0);
        rd(3'd4, r); check("home_status", r, 32'h13);
        check("home_irq", {31'b0, irq}, 32'd1);
        check("home_en_off", {31'b0, motor_en}, 32'd0);
        wr(3'd4, 32'h0);
        check("irq_clear", {31'b0, irq}, 32'd0);

        // Move to 100 with tolerance 2
        wr(3'd2, 32'd100); wr(3'd6, 32'd2); wr(3'd1, 32'h2);
        cyc(2);
        check("move_dir", {31'b0, motor_dir}, 32'd1);
        repeat (97) enc(1);
        cyc(4);
        check("en_at_97", {31'b0, motor_en}, 32'd1);
        set_phase(1);
        cyc(3); check("en_pos98_pending", {31'b0, motor_en}, 32'd1);
        cyc(1); check("en_done_after98", {31'b0, motor_en}, 32'd0);
        rd(3'd3, r); check("move_pos", r, 32'd98);
        rd(3'd4, r); check("move_status", r, 32'h13);

        // Abort then immediate re-move
        wr(3'd4, 32'h0);
        wr(3'd2, 32'd500); wr(3'd1, 32'h2);
        check("move2_en", {31'b0, motor_en}, 32'd1);
        repeat (3) enc(1);
        wr(3'd1, 32'h4);
        check("abort_en", {31'b0, motor_en}, 32'd0);
        rd(3'd4, r); check("abort_status", r, 32'h0);
        wr(3'd1, 32'h2);
        check("remove_en", {31'b0, motor_en}, 32'd1);
        rd(3'd4, r); check("remove_status", r, 32'h42);
        wr(3'd1, 32'h4);

        // Illegal transition is ignored and sticky
        enc(2); cyc(2);
        rd(3'd4, r); check("illegal_status", r, 32'h80);
        rd(3'd3, r); check("illegal_pos", r, 32'd101);
        wr(3'd4, 32'h0);

`ifdef ENCODER_SEQ_TIMEOUT_EN
        wr(3'd5, 32'd50);
        rd(3'd5, r); check("timeout_rd", r, 32'd50);
        wr(3'd1, 32'h1);
        cyc(49); check("wd_not_yet", {31'b0, motor_en}, 32'd1);
        cyc(1);  check("wd_fault_en", {31'b0, motor_en}, 32'd0);
        check("wd_fault_irq", {31'b0, irq}, 32'd1);
        rd(3'd4, r); check("wd_fault_status", r, 32'h24);
        wr(3'd4, 32'h0);
`else
        rd(3'd5, r); check("timeout_absent", r, 32'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: enc(1);
                3, 4:    enc(-1);
                5:       enc(($urandom_range(0, 7) == 0) ? 2 : 1);
                6: begin
                    z = 1'b1; cyc($urandom_range(1, 3)); z = 1'b0; cyc(1);
                end
                7: begin
                    logic [2:0] ad;
                    logic [31:0] d;
                    ad = 3'($urandom_range(1, 6));
                    case (ad)
                        3'd1:    d = 32'($urandom_range(0, 7));
                        3'd2:    d = 32'($urandom_range(0, 200));
                        3'd3:    d = 32'($urandom_range(0, 100));
                        3'd5:    d = 32'($urandom_range(5, 80));
                        3'd6:    d = 32'($urandom_range(0, 10));
                        default: d = $urandom;
                    endcase
                    wr(ad, d);
                end
                8: rd(3'($urandom_range(0, 7)), r);
                default: cyc($urandom_range(1, 4));
            endcase
        end

        // Reset in mid-operation drops the motor outputs at once
        ph = 0; {a, b} = 2'b00; z = 1'b0;
        cyc(4);
        wr(3'd1, 32'h4);
        wr(3'd1, 32'h1);
        check("pre_reset_en", {31'b0, motor_en}, 32'd1);
        #2 rst = 1'b1;
        #1 check("async_reset_en", {31'b0, motor_en}, 32'd0);
        check("async_reset_irq", {31'b0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd(3'd3, r); check("post_reset_pos", r, 32'd0);
        rd(3'd4, r); check("post_reset_status", r, 32'd0);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
